// File: rtl/alu_instr_encoder_pkg.sv
// Shared encoding constants and helpers for the ALU instruction encoder.
package alu_enc_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [1:0] FORM_REG = 2'b11;
  localparam logic [1:0] FORM_IMM = 2'b01;

  // op = {instr[30], funct3[2:0], instr[5:4]}
  localparam int OP_ALT_BIT  = 5;
  localparam int OP_F3_MSB   = 4;
  localparam int OP_F3_LSB   = 2;
  localparam int OP_FORM_MSB = 1;
  localparam int OP_FORM_LSB = 0;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [11:0] imm;
  } alu_req_t;

  function automatic logic [2:0] op_f3(input logic [5:0] op);
    return op[OP_F3_MSB:OP_F3_LSB];
  endfunction

  function automatic logic [1:0] op_form(input logic [5:0] op);
    return op[OP_FORM_MSB:OP_FORM_LSB];
  endfunction

  // Shifts (funct3 001/101) carry the alt bit and a 5-bit shamt in the imm field.
  function automatic logic [31:0] encode(input alu_req_t r);
    logic [2:0] f3;
    logic       alt;
    f3  = op_f3(r.op);
    alt = r.op[OP_ALT_BIT];
    if (op_form(r.op) == FORM_REG)
      return {1'b0, alt, 5'b0, r.rs2, r.rs1, f3, r.rd, OPC_OP};
    else if (f3 == F3_SLL || f3 == F3_SR)
      return {1'b0, alt, 5'b0, r.imm[4:0], r.rs1, f3, r.rd, OPC_OP_IMM};
    else
      return {r.imm, r.rs1, f3, r.rd, OPC_OP_IMM};
  endfunction

  // Only SUB/SRA (register) and SRAI (immediate) may set the alt bit.
  function automatic logic is_illegal(input logic [5:0] op);
    logic [2:0] f3;
    logic       alt;
    f3  = op_f3(op);
    alt = op[OP_ALT_BIT];
    case (op_form(op))
      FORM_REG: return alt && !(f3 == F3_ADD || f3 == F3_SR);
      FORM_IMM: return alt && (f3 != F3_SR);
      default:  return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/alu_instr_encoder_if.sv
// Request handshake and IMEM write bus of the ALU instruction encoder.
interface alu_enc_if;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_op;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [11:0] in_imm;
  logic        imem_we;
  logic        imem_ready;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;

  // Producer of requests / consumer of IMEM writes.
  modport master (
    output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, imem_ready,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  // Encoder side.
  modport slave (
    input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, imem_ready,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/alu_instr_encoder_sync_fifo.sv
// Synchronous FIFO, power-of-2 depth, head visible combinationally on rdata.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] r_mem;
  logic [AW:0]                 r_wptr;
  logic [AW:0]                 r_rptr;
  logic                        w_do_push;
  logic                        w_do_pop;

  // Extra pointer bit tells full from empty when the indices match.
  assign empty     = (r_wptr == r_rptr);
  assign full      = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;
  assign rdata     = r_mem[r_rptr[AW-1:0]];

  // Storage; cleared on reset so the head reads zero afterwards.
  always_ff @(posedge clk) begin
    if (reset)          r_mem <= '0;
    else if (w_do_push) r_mem[r_wptr[AW-1:0]] <= wdata;
  end

  // Read/write pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_do_pop)  r_rptr <= r_rptr + (AW+1)'(1);
    end
  end
endmodule

// File: rtl/alu_instr_encoder.sv
// Encodes decoded ALU ops into RV32I OP/OP-IMM words and streams them into IMEM.
module alu_instr_encoder
  import alu_enc_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic          clk,
  input  logic          reset,
  alu_enc_if.slave      bus,
  output logic          illegal,
  output logic [7:0]    illegal_count,
  output logic [15:0]   words_written
);
  alu_req_t    w_req;
  logic [31:0] w_word;
  logic        w_illegal;
  logic        w_accept;
  logic        w_push;
  logic        w_pop;
  logic        w_full;
  logic        w_empty;
  logic [31:0] w_head;

  logic [31:0] r_addr;
  logic        r_illegal;
  logic [7:0]  r_ill_cnt;
  logic [15:0] r_words;

  assign w_req     = '{op: bus.in_op, rd: bus.in_rd, rs1: bus.in_rs1, rs2: bus.in_rs2, imm: bus.in_imm};
  assign w_word    = encode(w_req);
  assign w_illegal = is_illegal(bus.in_op);

  // Readiness ignores legality; illegal ops are accepted then dropped.
  assign w_accept  = bus.in_valid && !w_full && !reset;
  assign w_push    = w_accept && !w_illegal;
  assign w_pop     = bus.imem_ready && !w_empty;

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .wdata (w_word),
    .pop   (w_pop),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

  assign bus.in_ready   = !w_full;
  assign bus.imem_we    = !w_empty;
  assign bus.imem_wdata = w_head;
  assign bus.imem_addr  = r_addr;
  assign illegal        = r_illegal;
  assign illegal_count  = r_ill_cnt;
  assign words_written  = r_words;

  // Write address and completed-write count advance on each accepted IMEM write.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr  <= BASE_ADDR;
      r_words <= '0;
    end else if (w_pop) begin
      r_addr  <= r_addr + 32'd4;
      r_words <= r_words + 16'd1;
    end
  end

  // Sticky illegal flag and saturating illegal counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_illegal <= 1'b0;
      r_ill_cnt <= '0;
    end else if (w_accept && w_illegal) begin
      r_illegal <= 1'b1;
      if (r_ill_cnt != 8'hFF) r_ill_cnt <= r_ill_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_alu_instr_encoder.sv
// Randomized + directed bench for alu_instr_encoder against a queue-based model.
module tb_alu_instr_encoder;
  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0;

  logic        clk = 1'b0;
  logic        reset;
  logic        illegal;
  logic [7:0]  illegal_count;
  logic [15:0] words_written;

  alu_enc_if bus();

  alu_instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .illegal       (illegal),
    .illegal_count (illegal_count),
    .words_written (words_written)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model state
  logic [31:0] mq[$];
  logic [31:0] m_addr;
  bit          m_ill;
  int          m_ill_cnt;
  int          m_ww;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", tag, act, exp);
    end
  endtask

  // Instruction word from its fields, built by arithmetic placement.
  function automatic logic [31:0] ref_word(input logic [5:0] op, input int rd, input int rs1,
                                           input int rs2, input int imm);
    int unsigned f3, alt, w;
    f3  = (op >> 2) & 7;
    alt = (op >> 5) & 1;
    w   = rd * 128 + f3 * 4096 + rs1 * 32768;
    if ((op & 3) == 3)
      w = w + 32'h33 + rs2 * (1 << 20) + alt * (1 << 30);
    else if (f3 == 1 || f3 == 5)
      w = w + 32'h13 + (imm % 32) * (1 << 20) + alt * (1 << 30);
    else
      w = w + 32'h13 + imm * (1 << 20);
    return w;
  endfunction

  function automatic bit ref_legal(input logic [5:0] op);
    int unsigned f3, alt, form;
    f3   = (op >> 2) & 7;
    alt  = (op >> 5) & 1;
    form = op & 3;
    if (form == 3) return (alt == 0) || (f3 == 0) || (f3 == 5);
    if (form == 1) return (alt == 0) || (f3 == 5);
    return 0;
  endfunction

  task automatic drive(input bit v, input logic [5:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [11:0] imm);
    bus.in_valid = v;
    bus.in_op    = op;
    bus.in_rd    = rd;
    bus.in_rs1   = rs1;
    bus.in_rs2   = rs2;
    bus.in_imm   = imm;
  endtask

  task automatic check_all();
    chk("in_ready", {31'b0, bus.in_ready}, {31'b0, mq.size() < DEPTH});
    chk("imem_we", {31'b0, bus.imem_we}, {31'b0, mq.size() > 0});
    if (mq.size() > 0) chk("imem_wdata", bus.imem_wdata, mq[0]);
    chk("imem_addr", bus.imem_addr, m_addr);
    chk("illegal", {31'b0, illegal}, {31'b0, m_ill});
    chk("illegal_count", {24'b0, illegal_count}, m_ill_cnt);
    chk("words_written", {16'b0, words_written}, m_ww);
  endtask

  // One clock: update model from inputs at the edge, then check at the falling edge.
  task automatic step();
    bit acc, wr;
    @(posedge clk);
    if (reset) begin
      mq.delete();
      m_addr = BASE; m_ill = 0; m_ill_cnt = 0; m_ww = 0;
    end else begin
      acc = bus.in_valid && (mq.size() < DEPTH);
      wr  = (mq.size() > 0) && bus.imem_ready;
      if (wr) begin
        void'(mq.pop_front());
        m_addr = m_addr + 32'd4;
        m_ww   = (m_ww + 1) % 65536;
      end
      if (acc) begin
        if (ref_legal(bus.in_op))
          mq.push_back(ref_word(bus.in_op, bus.in_rd, bus.in_rs1, bus.in_rs2, bus.in_imm));
        else begin
          m_ill = 1;
          if (m_ill_cnt < 255) m_ill_cnt++;
        end
      end
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 6'b0, 5'd0, 5'd0, 5'd0, 12'd0);
    step();
    reset = 1'b0;
  endtask

  // Present a request until accepted, bounded.
  task automatic send(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [11:0] imm);
    bit ok;
    ok = 0;
    drive(1, op, rd, rs1, rs2, imm);
    for (int n = 0; n < 50 && !ok; n++) begin
      ok = bus.in_ready;
      step();
    end
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
    drive(0, 6'b0, 5'd0, 5'd0, 5'd0, 12'd0);
  endtask

  initial begin
    reset = 1'b1;
    bus.imem_ready = 1'b0;
    drive(0, 6'b0, 5'd0, 5'd0, 5'd0, 12'd0);
    @(negedge clk);
    do_reset();
    chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("rst_imem_we", {31'b0, bus.imem_we}, 32'd0);
    chk("rst_imem_addr", bus.imem_addr, BASE);
    chk("rst_imem_wdata", bus.imem_wdata, 32'd0);

    // ADD x3,x1,x2
    bus.imem_ready = 1'b1;
    send(6'b000011, 5'd3, 5'd1, 5'd2, 12'd0);
    chk("add_word", bus.imem_wdata, 32'h002081B3);
    chk("add_addr", bus.imem_addr, 32'h0);
    step();
    chk("add_ww", {16'b0, words_written}, 32'd1);

    // SUB x5,x6,x7 then ADDI x1,x0,-1
    do_reset();
    bus.imem_ready = 1'b0;
    send(6'b100011, 5'd5, 5'd6, 5'd7, 12'd0);
    send(6'b000001, 5'd1, 5'd0, 5'd0, 12'hFFF);
    chk("sub_word", bus.imem_wdata, 32'h407302B3);
    chk("sub_addr", bus.imem_addr, 32'h0);
    bus.imem_ready = 1'b1;
    step();
    chk("addi_word", bus.imem_wdata, 32'hFFF00093);
    chk("addi_addr", bus.imem_addr, 32'h4);
    step();

    // SRAI x2,x1,3 with junk upper imm bits
    bus.imem_ready = 1'b0;
    send(6'b110101, 5'd2, 5'd1, 5'd0, 12'hFE3);
    chk("srai_word", bus.imem_wdata, 32'h4030D113);
    bus.imem_ready = 1'b1;
    step();

    // Fill to full with IMEM stalled, then drain
    do_reset();
    bus.imem_ready = 1'b0;
    for (int k = 0; k < 4; k++) send(6'b000011, 5'(k + 1), 5'd1, 5'd2, 12'd0);
    drive(1, 6'b000011, 5'd9, 5'd1, 5'd2, 12'd0);
    step();
    chk("full_in_ready", {31'b0, bus.in_ready}, 32'd0);
    bus.imem_ready = 1'b1;
    step();
    chk("full_no_push", {29'b0, 3'(mq.size())}, 32'd3);
    step();
    drive(0, 6'b0, 5'd0, 5'd0, 5'd0, 12'd0);
    for (int k = 0; k < 4; k++) step();
    chk("drain_ww", {16'b0, words_written}, 32'd5);
    chk("drain_addr", bus.imem_addr, 32'h14);

    // Illegal ops then a legal ADD
    do_reset();
    bus.imem_ready = 1'b0;
    send(6'b100111, 5'd1, 5'd1, 5'd1, 12'd0);
    send(6'b000010, 5'd1, 5'd1, 5'd1, 12'd0);
    chk("ill_no_we", {31'b0, bus.imem_we}, 32'd0);
    send(6'b000011, 5'd3, 5'd1, 5'd2, 12'd0);
    chk("ill_flag", {31'b0, illegal}, 32'd1);
    chk("ill_cnt", {24'b0, illegal_count}, 32'd2);
    chk("ill_add_word", bus.imem_wdata, 32'h002081B3);
    chk("ill_add_addr", bus.imem_addr, 32'h0);

    // Reset with entries queued; request present during reset
    do_reset();
    bus.imem_ready = 1'b0;
    for (int k = 0; k < 3; k++) send(6'b000111, 5'(k), 5'd2, 5'd3, 12'd0);
    reset = 1'b1;
    drive(1, 6'b000011, 5'd4, 5'd4, 5'd4, 12'd0);
    step();
    reset = 1'b0;
    drive(0, 6'b0, 5'd0, 5'd0, 5'd0, 12'd0);
    chk("rmid_we", {31'b0, bus.imem_we}, 32'd0);
    chk("rmid_addr", bus.imem_addr, BASE);
    chk("rmid_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("rmid_ww", {16'b0, words_written}, 32'd0);
    bus.imem_ready = 1'b1;
    send(6'b000011, 5'd3, 5'd1, 5'd2, 12'd0);
    chk("rmid_new_addr", bus.imem_addr, BASE);
    step();

    // Saturation of illegal_count
    for (int k = 0; k < 260; k++) begin
      drive(1, 6'b000000, 5'd0, 5'd0, 5'd0, 12'd0);
      step();
    end
    drive(0, 6'b0, 5'd0, 5'd0, 5'd0, 12'd0);
    chk("ill_sat", {24'b0, illegal_count}, 32'd255);

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      reset = ($urandom_range(0, 299) == 0);
      bus.imem_ready = $urandom_range(0, 2) != 0;
      drive($urandom_range(0, 1), 6'($urandom), 5'($urandom), 5'($urandom),
            5'($urandom), 12'($urandom));
      if ($urandom_range(0, 1) == 1) bus.in_op[1:0] = 2'($urandom_range(0, 1) ? 3 : 1);
      step();
    end
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
